// File: rtl/bcd_timer_pkg.sv
// Shared encodings and helpers for the BCD stopwatch core and its BCD stepper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic bit digits_ok(input int d);
    return (d >= DIGITS_MIN) && (d <= DIGITS_MAX);
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Pulse/level controls into the stopwatch and its display-facing outputs.
// Controls are single-cycle pulses sampled on every clk edge; there is no back-pressure.
interface bcd_stopwatch_core_if #(
  parameter int DIGITS = 2
);
  logic                start_p;
  logic                lap_p;
  logic                clr_p;
  logic                dir;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] shown;
  logic [1:0]          state;
  logic                tick;
  logic                wrap_p;

  modport master (
    output start_p, lap_p, clr_p, dir,
    input  count, shown, state, tick, wrap_p
  );

  modport slave (
    input  start_p, lap_p, clr_p, dir,
    output count, shown, state, tick, wrap_p
  );
endinterface

// File: rtl/bcd_step.sv
// Combinational one-unit BCD increment/decrement with wrap at LIMIT (up) or 0 (down).
module bcd_step
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                dir_i,
  input  logic [4*DIGITS-1:0] limit_i,
  output logic [4*DIGITS-1:0] next_o,
  output logic                wrapped_o
);

  logic [3:0] digit;
  logic       carry;

  always_comb begin
    next_o    = value_i;
    wrapped_o = 1'b0;
    digit     = 4'h0;
    carry     = 1'b1;
    if (!dir_i && (value_i == limit_i)) begin
      next_o    = '0;
      wrapped_o = 1'b1;
    end else if (dir_i && (value_i == '0)) begin
      next_o    = limit_i;
      wrapped_o = 1'b1;
    end else begin
      // Ripple carry/borrow digit by digit so no binary intermediate ever appears.
      for (int i = 0; i < DIGITS; i++) begin
        digit = value_i[4*i +: 4];
        if (carry) begin
          if (!dir_i) begin
            if (digit == BCD_NINE) digit = 4'h0;
            else begin
              digit = digit + 4'h1;
              carry = 1'b0;
            end
          end else begin
            if (digit == 4'h0) digit = BCD_NINE;
            else begin
              digit = digit - 4'h1;
              carry = 1'b0;
            end
          end
        end
        next_o[4*i +: 4] = digit;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch: run/pause/lap FSM, tick prescaler, live count and lap hold.
module bcd_stopwatch_core
  import bcd_timer_pkg::*;
#(
  parameter int                  DIGITS   = 2,
  parameter int                  TICK_MAX = 10_000_000 - 1,
  parameter logic [4*DIGITS-1:0] LIMIT    = {DIGITS{4'h9}}
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_stopwatch_core_if.slave  sw
);

  localparam int             PW      = (TICK_MAX < 2) ? 1 : $clog2(TICK_MAX + 1);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_MAX);

  if (!digits_ok(DIGITS)) begin : g_bad_digits
    $error("bcd_stopwatch_core: DIGITS must be 1..8");
  end

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] step_next;
  logic                step_wrap;
  logic                running;
  logic                tick;

  bcd_step #(.DIGITS(DIGITS)) u_step (
    .value_i   (count_q),
    .dir_i     (sw.dir),
    .limit_i   (LIMIT),
    .next_o    (step_next),
    .wrapped_o (step_wrap)
  );

  assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick    = running && (pre_q == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lap_q   <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
    end
  end

  // Tick and prescaler act on the current state, so a tick coinciding with a
  // start/lap pulse still lands; only clear overrides it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    if (sw.clr_p) begin
      state_d = ST_IDLE;
      count_d = '0;
      lap_d   = '0;
      pre_d   = '0;
    end else begin
      if (state_q == ST_IDLE) pre_d = '0;
      else if (running)       pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        count_d = step_next;
        wrap_d  = step_wrap;
      end
      if (sw.start_p) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: state_d = ST_RUN;
          default:           state_d = ST_PAUSE;
        endcase
      end else if (sw.lap_p) begin
        if (state_q == ST_RUN) begin
          state_d = ST_LAP;
          lap_d   = count_q;
        end else if (state_q == ST_LAP) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  assign sw.count  = count_q;
  assign sw.shown  = (state_q == ST_LAP) ? lap_q : count_q;
  assign sw.state  = state_q;
  assign sw.tick   = tick;
  assign sw.wrap_p = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench: 2-digit 0..30 instance for control/wrap/lap, 4-digit instance for ripple and async reset.
module tb_bcd_stopwatch_core;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_stopwatch_core_if #(.DIGITS(2)) sw_a ();
  bcd_stopwatch_core_if #(.DIGITS(4)) sw_b ();

  bcd_stopwatch_core #(.DIGITS(2), .TICK_MAX(3), .LIMIT(8'h30)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .sw  (sw_a)
  );

  bcd_stopwatch_core #(.DIGITS(4), .TICK_MAX(1), .LIMIT(16'h9999)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .sw  (sw_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic s, input logic l, input logic c);
    sw_a.start_p = s;
    sw_a.lap_p   = l;
    sw_a.clr_p   = c;
    step(1);
    sw_a.start_p = 1'b0;
    sw_a.lap_p   = 1'b0;
    sw_a.clr_p   = 1'b0;
  endtask

  task automatic pulse_b_start();
    sw_b.start_p = 1'b1;
    step(1);
    sw_b.start_p = 1'b0;
  endtask

  task automatic wait_tick_a();
    int budget;
    budget = 0;
    while (sw_a.tick !== 1'b1 && budget < 20) begin
      step(1);
      budget++;
    end
    if (sw_a.tick !== 1'b1) check("tick_timeout_a", 32'(sw_a.tick), 32'h1);
  endtask

  task automatic run_ticks_a(input int n);
    for (int k = 0; k < n; k++) begin
      wait_tick_a();
      step(1);
    end
  endtask

  task automatic run_ticks_b(input int n);
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (sw_b.tick !== 1'b1 && budget < 20) begin
        step(1);
        budget++;
      end
      if (sw_b.tick !== 1'b1) check("tick_timeout_b", 32'(sw_b.tick), 32'h1);
      step(1);
    end
  endtask

  function automatic logic [31:0] to_bcd2(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  initial begin
    logic [31:0] e;
    sw_a.start_p = 1'b0; sw_a.lap_p = 1'b0; sw_a.clr_p = 1'b0; sw_a.dir = 1'b0;
    sw_b.start_p = 1'b0; sw_b.lap_p = 1'b0; sw_b.clr_p = 1'b0; sw_b.dir = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(3);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    check("rst_count", 32'(sw_a.count), 32'h0);
    check("rst_shown", 32'(sw_a.shown), 32'h0);
    check("rst_state", 32'(sw_a.state), 32'h0);
    check("rst_tick",  32'(sw_a.tick),  32'h0);
    check("rst_wrap",  32'(sw_a.wrap_p), 32'h0);
    step(2);
    check("idle_hold_count", 32'(sw_a.count), 32'h0);

    // Start latency: state next cycle, tick at n+4, count at n+5
    pulse_a(1'b1, 1'b0, 1'b0);
    check("start_state", 32'(sw_a.state), 32'h1);
    check("start_tick_n1", 32'(sw_a.tick), 32'h0);
    step(2);
    check("start_tick_n3", 32'(sw_a.tick), 32'h0);
    step(1);
    check("start_tick_n4", 32'(sw_a.tick), 32'h1);
    check("start_count_n4", 32'(sw_a.count), 32'h00);
    step(1);
    check("start_count_n5", 32'(sw_a.count), 32'h01);
    check("start_tick_n5", 32'(sw_a.tick), 32'h0);
    step(3);
    check("period_tick", 32'(sw_a.tick), 32'h1);
    step(1);
    check("period_count", 32'(sw_a.count), 32'h02);

    // Up count through LIMIT=30 and wrap to 00
    for (int k = 3; k <= 31; k++) exp_q.push_back(to_bcd2(k % 31));
    for (int k = 3; k <= 31; k++) begin
      run_ticks_a(1);
      e = exp_q.pop_front();
      check("up_count", 32'(sw_a.count), e);
      check("up_wrap", 32'(sw_a.wrap_p), (k == 31) ? 32'h1 : 32'h0);
    end
    step(1);
    check("wrap_one_cycle", 32'(sw_a.wrap_p), 32'h0);

    // Down wrap 00 -> 30 -> 29
    sw_a.dir = 1'b1;
    run_ticks_a(1);
    check("down_wrap_count", 32'(sw_a.count), 32'h30);
    check("down_wrap_flag", 32'(sw_a.wrap_p), 32'h1);
    run_ticks_a(1);
    check("down_next_count", 32'(sw_a.count), 32'h29);
    check("down_next_flag", 32'(sw_a.wrap_p), 32'h0);
    sw_a.dir = 1'b0;

    // Clear, then lap at 07 held while live count reaches 12
    pulse_a(1'b0, 1'b0, 1'b1);
    check("clr_state", 32'(sw_a.state), 32'h0);
    check("clr_count", 32'(sw_a.count), 32'h0);
    pulse_a(1'b1, 1'b0, 1'b0);
    run_ticks_a(7);
    check("lap_pre_count", 32'(sw_a.count), 32'h07);
    pulse_a(1'b0, 1'b1, 1'b0);
    check("lap_state", 32'(sw_a.state), 32'h3);
    check("lap_shown", 32'(sw_a.shown), 32'h07);
    run_ticks_a(5);
    check("lap_live_count", 32'(sw_a.count), 32'h12);
    check("lap_shown_held", 32'(sw_a.shown), 32'h07);
    pulse_a(1'b0, 1'b1, 1'b0);
    check("lap_release_state", 32'(sw_a.state), 32'h1);
    check("lap_release_shown", 32'(sw_a.shown), 32'h12);

    // Pause mid-period: prescaler sits at 3, resume ticks after one cycle
    step(1);
    pulse_a(1'b1, 1'b0, 1'b0);
    check("pause_state", 32'(sw_a.state), 32'h2);
    step(10);
    check("pause_count", 32'(sw_a.count), 32'h12);
    check("pause_tick", 32'(sw_a.tick), 32'h0);
    pulse_a(1'b1, 1'b0, 1'b0);
    check("resume_state", 32'(sw_a.state), 32'h1);
    check("resume_tick", 32'(sw_a.tick), 32'h1);
    step(1);
    check("resume_count", 32'(sw_a.count), 32'h13);

    // start_p + lap_p together in RUN: pause wins, no lap
    pulse_a(1'b1, 1'b1, 1'b0);
    check("prio_state", 32'(sw_a.state), 32'h2);
    check("prio_shown", 32'(sw_a.shown), 32'h13);
    pulse_a(1'b1, 1'b0, 1'b0);

    // clr_p coincident with tick: clear wins
    wait_tick_a();
    pulse_a(1'b0, 1'b0, 1'b1);
    check("clr_tick_state", 32'(sw_a.state), 32'h0);
    check("clr_tick_count", 32'(sw_a.count), 32'h0);
    check("clr_tick_wrap", 32'(sw_a.wrap_p), 32'h0);
    step(6);
    check("clr_idle_count", 32'(sw_a.count), 32'h0);

    // Lap on a tick cycle captures the pre-increment count
    pulse_a(1'b1, 1'b0, 1'b0);
    wait_tick_a();
    pulse_a(1'b0, 1'b1, 1'b0);
    check("lap_tick_state", 32'(sw_a.state), 32'h3);
    check("lap_tick_shown", 32'(sw_a.shown), 32'h00);
    check("lap_tick_count", 32'(sw_a.count), 32'h01);

    // 4-digit ripple 0999 -> 1000, then async reset mid-run
    check("b_rst_count", 32'(sw_b.count), 32'h0);
    pulse_b_start();
    check("b_start_state", 32'(sw_b.state), 32'h1);
    run_ticks_b(999);
    check("b_count_0999", 32'(sw_b.count), 32'h0999);
    run_ticks_b(1);
    check("b_ripple_1000", 32'(sw_b.count), 32'h1000);
    step(1);
    #2 rst_b = 1'b1;
    #1;
    check("b_async_count", 32'(sw_b.count), 32'h0);
    check("b_async_state", 32'(sw_b.state), 32'h0);
    check("b_async_shown", 32'(sw_b.shown), 32'h0);
    check("b_async_tick", 32'(sw_b.tick), 32'h0);
    step(1);
    rst_b = 1'b0;
    pulse_b_start();
    check("b_post_rst_state", 32'(sw_b.state), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
